// File: rtl/ext_subsys_pwr_seq.sv
// Power-gating sequencer for the external (CGRA) domain: clock gate, isolation, reset, switch with ack.
// Optional ack-wait timeout with sticky err_o is compiled in with `define EXT_PWR_SEQ_TIMEOUT_EN.
module ext_subsys_pwr_seq #(
    parameter int STEP_CYCLES    = 2,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W = $clog2((((STEP_CYCLES > SETTLE_CYCLES) ? STEP_CYCLES : SETTLE_CYCLES)
                                  > TIMEOUT_CYCLES)
                                 ? ((STEP_CYCLES > SETTLE_CYCLES) ? STEP_CYCLES : SETTLE_CYCLES)
                                 : TIMEOUT_CYCLES) + 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       pwr_off_req_i,
    input  logic       busy_i,
    input  logic       switch_ack_ni,
    input  logic       err_clr_i,
    output logic       clkgate_en_no,
    output logic       iso_no,
    output logic       domain_rst_no,
    output logic       switch_no,
    output logic [3:0] state_o,
    output logic       done_o,
    output logic       err_o
);

    typedef enum logic [3:0] {
        ON      = 4'd0,
        GATE    = 4'd1,
        ISO     = 4'd2,
        RST     = 4'd3,
        SW_OFF  = 4'd4,
        OFF     = 4'd5,
        SW_ON   = 4'd6,
        SETTLE  = 4'd7,
        RST_REL = 4'd8,
        ISO_REL = 4'd9
    } state_t;

    // Control word order: {clkgate_en_no, iso_no, domain_rst_no, switch_no}
    localparam logic [3:0] CTRL_ON      = 4'b0110;
    localparam logic [3:0] CTRL_GATE    = 4'b1110;
    localparam logic [3:0] CTRL_ISO     = 4'b1010;
    localparam logic [3:0] CTRL_RST     = 4'b1000;
    localparam logic [3:0] CTRL_SW_OFF  = 4'b1001;
    localparam logic [3:0] CTRL_SW_ON   = 4'b1000;
    localparam logic [3:0] CTRL_RST_REL = 4'b1010;
    localparam logic [3:0] CTRL_ISO_REL = 4'b1110;

    localparam logic [CNT_W-1:0] STEP_LD   = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state;
    logic [3:0]       ctrl;
    logic [CNT_W-1:0] cnt;
    logic             ack_s1;
    logic             ack_s2;
    logic             tmo;

    assign {clkgate_en_no, iso_no, domain_rst_no, switch_no} = ctrl;
    assign state_o = state;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_s1 <= 1'b0;
            ack_s2 <= 1'b0;
        end else begin
            ack_s1 <= switch_ack_ni;
            ack_s2 <= ack_s1;
        end
    end

`ifdef EXT_PWR_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(TIMEOUT_CYCLES - 1);

    // The step counter doubles as the ack-wait counter while in SW_OFF/SW_ON.
    assign tmo = (cnt == '0) &&
                 (((state == SW_OFF) && !ack_s2) || ((state == SW_ON) && ack_s2));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_o <= 1'b0;
        end else if (tmo) begin
            err_o <= 1'b1;
        end else if (err_clr_i) begin
            err_o <= 1'b0;
        end
    end
`else
    localparam logic [CNT_W-1:0] WAIT_LD = '0;
    logic unused_err_clr;

    assign tmo            = 1'b0;
    assign err_o          = 1'b0;
    assign unused_err_clr = err_clr_i;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= ON;
            ctrl   <= CTRL_ON;
            cnt    <= '0;
            done_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            case (state)
                ON: begin
                    if (pwr_off_req_i && !busy_i) begin
                        state <= GATE;
                        ctrl  <= CTRL_GATE;
                        cnt   <= STEP_LD;
                    end
                end
                GATE: begin
                    if (cnt == '0) begin
                        state <= ISO;
                        ctrl  <= CTRL_ISO;
                        cnt   <= STEP_LD;
                    end
                end
                ISO: begin
                    if (cnt == '0) begin
                        state <= RST;
                        ctrl  <= CTRL_RST;
                        cnt   <= STEP_LD;
                    end
                end
                RST: begin
                    if (cnt == '0) begin
                        state <= SW_OFF;
                        ctrl  <= CTRL_SW_OFF;
                        cnt   <= WAIT_LD;
                    end
                end
                SW_OFF: begin
                    if (ack_s2 || tmo) begin
                        state  <= OFF;
                        done_o <= 1'b1;
                    end
                end
                OFF: begin
                    if (!pwr_off_req_i) begin
                        state <= SW_ON;
                        ctrl  <= CTRL_SW_ON;
                        cnt   <= WAIT_LD;
                    end
                end
                SW_ON: begin
                    if (!ack_s2 || tmo) begin
                        state <= SETTLE;
                        cnt   <= SETTLE_LD;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        state <= RST_REL;
                        ctrl  <= CTRL_RST_REL;
                        cnt   <= STEP_LD;
                    end
                end
                RST_REL: begin
                    if (cnt == '0) begin
                        state <= ISO_REL;
                        ctrl  <= CTRL_ISO_REL;
                        cnt   <= STEP_LD;
                    end
                end
                ISO_REL: begin
                    if (cnt == '0) begin
                        state  <= ON;
                        ctrl   <= CTRL_ON;
                        done_o <= 1'b1;
                    end
                end
                default: begin
                    state <= ON;
                    ctrl  <= CTRL_ON;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ext_subsys_pwr_seq.sv
// Directed bench for ext_subsys_pwr_seq with STEP=2, SETTLE=4, TIMEOUT=16.
// Timeout scenario follows EXT_PWR_SEQ_TIMEOUT_EN as compiled.
module tb_ext_subsys_pwr_seq;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       pwr_off_req_i = 1'b0;
    logic       busy_i = 1'b0;
    logic       switch_ack_ni = 1'b0;
    logic       err_clr_i = 1'b0;
    logic       clkgate_en_no;
    logic       iso_no;
    logic       domain_rst_no;
    logic       switch_no;
    logic [3:0] state_o;
    logic       done_o;
    logic       err_o;
    logic [8:0] obs;

    int checks = 0;
    int errors = 0;

    ext_subsys_pwr_seq #(
        .STEP_CYCLES   (2),
        .SETTLE_CYCLES (4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .pwr_off_req_i(pwr_off_req_i),
        .busy_i       (busy_i),
        .switch_ack_ni(switch_ack_ni),
        .err_clr_i    (err_clr_i),
        .clkgate_en_no(clkgate_en_no),
        .iso_no       (iso_no),
        .domain_rst_no(domain_rst_no),
        .switch_no    (switch_no),
        .state_o      (state_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    // {state, clkgate_en_no, iso_no, domain_rst_no, switch_no, done}
    assign obs = {state_o, clkgate_en_no, iso_no, domain_rst_no, switch_no, done_o};

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] exp;
        rst_ni = 1'b0;
        pwr_off_req_i = 1'b0;
        busy_i = 1'b0;
        switch_ack_ni = 1'b0;
        err_clr_i = 1'b0;
        tick();
        tick();
        exp = {4'd0, 4'b0110, 1'b0};
        checks++;
        if (obs !== exp || err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold obs=%h err=%b exp=%h err=0", obs, err_o, exp);
        end
        rst_ni = 1'b1;
        for (int e = 1; e <= 50; e++) begin
            tick();
            checks++;
            if (obs !== exp || err_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle_e%0d obs=%h err=%b exp=%h err=0", e, obs, err_o, exp);
            end
        end
    endtask

    task automatic test_power_down();
        logic [8:0] exp;
        pwr_off_req_i = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            tick();
            if (e <= 2)       exp = {4'd1, 4'b1110, 1'b0};
            else if (e <= 4)  exp = {4'd2, 4'b1010, 1'b0};
            else if (e <= 6)  exp = {4'd3, 4'b1000, 1'b0};
            else if (e <= 14) exp = {4'd4, 4'b1001, 1'b0};
            else if (e == 15) exp = {4'd5, 4'b1001, 1'b1};
            else              exp = {4'd5, 4'b1001, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL pwr_down_e%0d obs=%h exp=%h", e, obs, exp);
            end
            if (e == 12) switch_ack_ni = 1'b1;
        end
    endtask

    task automatic test_wake();
        logic [8:0] exp;
        pwr_off_req_i = 1'b0;
        for (int e = 1; e <= 13; e++) begin
            tick();
            if (e <= 3)       exp = {4'd6, 4'b1000, 1'b0};
            else if (e <= 7)  exp = {4'd7, 4'b1000, 1'b0};
            else if (e <= 9)  exp = {4'd8, 4'b1010, 1'b0};
            else if (e <= 11) exp = {4'd9, 4'b1110, 1'b0};
            else if (e == 12) exp = {4'd0, 4'b0110, 1'b1};
            else              exp = {4'd0, 4'b0110, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL wake_e%0d obs=%h exp=%h", e, obs, exp);
            end
            if (e == 1) switch_ack_ni = 1'b0;
        end
    endtask

    task automatic test_busy_and_rerequest();
        logic [8:0] exp;
        bit         reached;
        busy_i = 1'b1;
        pwr_off_req_i = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            exp = {4'd0, 4'b0110, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL busy_hold_e%0d obs=%h exp=%h", e, obs, exp);
            end
        end
        busy_i = 1'b0;
        for (int e = 1; e <= 11; e++) begin
            tick();
            if (e <= 2)       exp = {4'd1, 4'b1110, 1'b0};
            else if (e <= 4)  exp = {4'd2, 4'b1010, 1'b0};
            else if (e <= 6)  exp = {4'd3, 4'b1000, 1'b0};
            else if (e <= 9)  exp = {4'd4, 4'b1001, 1'b0};
            else if (e == 10) exp = {4'd5, 4'b1001, 1'b1};
            else              exp = {4'd6, 4'b1000, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL rereq_e%0d obs=%h exp=%h", e, obs, exp);
            end
            if (e == 3) pwr_off_req_i = 1'b0;
            if (e == 7) switch_ack_ni = 1'b1;
        end
        switch_ack_ni = 1'b0;
        reached = 1'b0;
        for (int e = 12; e <= 40 && !reached; e++) begin
            tick();
            if (state_o == 4'd0) begin
                reached = 1'b1;
                exp = {4'd0, 4'b0110, 1'b1};
                checks++;
                if (obs !== exp || e != 22) begin
                    errors++;
                    $display("FAIL rereq_on_entry edge=%0d obs=%h exp_edge=22 exp=%h", e, obs, exp);
                end
            end
        end
        if (!reached) begin
            checks++;
            errors++;
            $display("FAIL rereq_wake_timeout state=%0d exp=0", state_o);
        end
    endtask

    task automatic test_timeout();
        logic [8:0] exp;
        switch_ack_ni = 1'b0;
        pwr_off_req_i = 1'b1;
        for (int e = 1; e <= 7; e++) tick();
        exp = {4'd4, 4'b1001, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL tmo_sw_off_entry obs=%h exp=%h", obs, exp);
        end
`ifdef EXT_PWR_SEQ_TIMEOUT_EN
        for (int e = 8; e <= 21; e++) tick();
        err_clr_i = 1'b1;
        tick();
        checks++;
        if (obs !== exp || err_o !== 1'b0) begin
            errors++;
            $display("FAIL tmo_before obs=%h err=%b exp=%h err=0", obs, err_o, exp);
        end
        tick();
        exp = {4'd5, 4'b1001, 1'b1};
        checks++;
        if (obs !== exp || err_o !== 1'b1) begin
            errors++;
            $display("FAIL tmo_fire obs=%h err=%b exp=%h err=1", obs, err_o, exp);
        end
        tick();
        err_clr_i = 1'b0;
        exp = {4'd5, 4'b1001, 1'b0};
        checks++;
        if (obs !== exp || err_o !== 1'b0) begin
            errors++;
            $display("FAIL tmo_clear obs=%h err=%b exp=%h err=0", obs, err_o, exp);
        end
`else
        for (int e = 8; e <= 1007; e++) tick();
        checks++;
        if (obs !== exp || err_o !== 1'b0) begin
            errors++;
            $display("FAIL no_tmo_wait obs=%h err=%b exp=%h err=0", obs, err_o, exp);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic [8:0] exp;
        switch_ack_ni = 1'b0;
        pwr_off_req_i = 1'b0;
        rst_ni = 1'b0;
        #2;
        rst_ni = 1'b1;
        pwr_off_req_i = 1'b1;
        for (int e = 1; e <= 5; e++) tick();
        exp = {4'd3, 4'b1000, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL mid_rst_state obs=%h exp=%h", obs, exp);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        exp = {4'd0, 4'b0110, 1'b0};
        checks++;
        if (obs !== exp || err_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_async obs=%h err=%b exp=%h err=0", obs, err_o, exp);
        end
        pwr_off_req_i = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
        tick();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL mid_rst_after obs=%h exp=%h", obs, exp);
        end
    endtask

    initial begin
        test_reset();
        test_power_down();
        test_wake();
        test_busy_and_rerequest();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog sim_time=%0t limit=100000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
